// File: rtl/sap_pkg.sv
// Shared definitions for the SAP-1 datapath: control-word layout, opcodes and
// the canned controller words used for NOP and instruction fetch.
package sap_pkg;

  localparam int unsigned CW_W = 12;

  // Bit positions inside the 12-bit control word.
  localparam int unsigned CP  = 11;
  localparam int unsigned EP  = 10;
  localparam int unsigned NLM = 9;
  localparam int unsigned NCE = 8;
  localparam int unsigned NLI = 7;
  localparam int unsigned NEI = 6;
  localparam int unsigned NLA = 5;
  localparam int unsigned EA  = 4;
  localparam int unsigned SU  = 3;
  localparam int unsigned EU  = 2;
  localparam int unsigned NLB = 1;
  localparam int unsigned NLO = 0;

  typedef enum logic [3:0] {
    LDA = 4'h0,
    ADD = 4'h1,
    SUB = 4'h2,
    OUT = 4'hE,
    HLT = 4'hF
  } opcode_e;

  localparam logic [CW_W-1:0] CW_NOP = 12'b0011_1110_0011;
  localparam logic [CW_W-1:0] CW_T1  = 12'h5E3;
  localparam logic [CW_W-1:0] CW_T2  = 12'hBE3;
  localparam logic [CW_W-1:0] CW_T3  = 12'h263;

  // Control word with every strobe normalised to active-high.
  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_t;

  function automatic ctrl_t decode_cw(input logic [CW_W-1:0] cw);
    ctrl_t c;
    c.cp = cw[CP];
    c.ep = cw[EP];
    c.lm = ~cw[NLM];
    c.ce = ~cw[NCE];
    c.li = ~cw[NLI];
    c.ei = ~cw[NEI];
    c.la = ~cw[NLA];
    c.ea = cw[EA];
    c.su = cw[SU];
    c.eu = cw[EU];
    c.lb = ~cw[NLB];
    c.lo = ~cw[NLO];
    return c;
  endfunction

endpackage

// File: rtl/sap_alu.sv
// Combinational add/subtract unit; result wraps modulo 2**DATA_W, no carry kept.
module sap_alu #(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              sub_i,
  output logic [DATA_W-1:0] result_o
);

  always_comb begin
    if (sub_i) begin
      result_o = a_i + ~b_i + DATA_W'(1);
    end else begin
      result_o = a_i + b_i;
    end
  end

endmodule

// File: rtl/sap_datapath.sv
// SAP-1 datapath: W-bus, PC, MAR, 16-word RAM, IR, A, B, ALU and output register,
// driven by the controller's control word and loadable through a programming port.
module sap_datapath
  import sap_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [CW_W-1:0]   control_word,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_value,
  output logic              halted,
  output logic [DATA_W-1:0] bus_value,
  output logic              bus_conflict
);

  ctrl_t ctl;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] out_q, out_d;

  logic [DATA_W-1:0] ram_q [2**ADDR_W];
  logic [DATA_W-1:0] alu_res;
  logic [DATA_W-1:0] bus;
  logic [2:0]        n_drv;

  // Programming mode substitutes the NOP word, so every register simply holds.
  assign ctl = decode_cw(prog_en ? CW_NOP : control_word);

  sap_alu #(.DATA_W(DATA_W)) u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .sub_i    (ctl.su),
    .result_o (alu_res)
  );

  always_comb begin
    bus = '0;
    if (ctl.ep) begin
      bus = {{(DATA_W-ADDR_W){1'b0}}, pc_q};
    end else if (ctl.ce) begin
      bus = ram_q[mar_q];
    end else if (ctl.ei) begin
      bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    end else if (ctl.ea) begin
      bus = a_q;
    end else if (ctl.eu) begin
      bus = alu_res;
    end
  end

  always_comb begin
    n_drv = 3'(ctl.ep) + 3'(ctl.ce) + 3'(ctl.ei) + 3'(ctl.ea) + 3'(ctl.eu);
  end

  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    ir_d  = ir_q;
    a_d   = a_q;
    b_d   = b_q;
    out_d = out_q;
    if (ctl.cp) pc_d  = pc_q + ADDR_W'(1);
    if (ctl.lm) mar_d = bus[ADDR_W-1:0];
    if (ctl.li) ir_d  = bus;
    if (ctl.la) a_d   = bus;
    if (ctl.lb) b_d   = bus;
    if (ctl.lo) out_d = bus;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q  <= '0;
      mar_q <= '0;
      ir_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      out_q <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      ir_q  <= ir_d;
      a_q   <= a_d;
      b_q   <= b_d;
      out_q <= out_d;
    end
  end

  // RAM has no reset so a loaded program survives a datapath reset.
  always_ff @(posedge clock) begin
    if (prog_en && prog_we) begin
      ram_q[prog_addr] <= prog_data;
    end
  end

  assign opcode       = ir_q[DATA_W-1 -: 4];
  assign halted       = (ir_q[DATA_W-1 -: 4] == HLT);
  assign out_value    = out_q;
  assign bus_value    = bus;
  assign bus_conflict = (n_drv > 3'd1);

endmodule

// File: tb/tb_sap_datapath.sv
// Directed bench for sap_datapath: a behavioural model checked every cycle,
// plus literal expectations taken from hand-worked SAP-1 sequences.
module tb_sap_datapath;

  localparam logic [11:0] MASK = 12'h3E3;
  localparam logic [11:0] F_CP = 12'h800;
  localparam logic [11:0] F_EP = 12'h400;
  localparam logic [11:0] F_LM = 12'h200;
  localparam logic [11:0] F_CE = 12'h100;
  localparam logic [11:0] F_LI = 12'h080;
  localparam logic [11:0] F_EI = 12'h040;
  localparam logic [11:0] F_LA = 12'h020;
  localparam logic [11:0] F_EA = 12'h010;
  localparam logic [11:0] F_SU = 12'h008;
  localparam logic [11:0] F_EU = 12'h004;
  localparam logic [11:0] F_LB = 12'h002;
  localparam logic [11:0] F_LO = 12'h001;

  logic        clock;
  logic        reset_n;
  logic [11:0] control_word;
  logic        prog_en;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [7:0]  prog_data;
  logic [3:0]  opcode;
  logic [7:0]  out_value;
  logic        halted;
  logic [7:0]  bus_value;
  logic        bus_conflict;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en = 1'b0;

  sap_datapath #(.DATA_W(8), .ADDR_W(4)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .control_word (control_word),
    .prog_en      (prog_en),
    .prog_we      (prog_we),
    .prog_addr    (prog_addr),
    .prog_data    (prog_data),
    .opcode       (opcode),
    .out_value    (out_value),
    .halted       (halted),
    .bus_value    (bus_value),
    .bus_conflict (bus_conflict)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  logic [3:0]  m_pc, m_mar;
  logic [7:0]  m_ir, m_a, m_b, m_out;
  logic [7:0]  m_ram [16];
  logic [11:0] m_act;
  logic [7:0]  m_busv;
  logic        m_conf;

  // Returns {conflict, bus}: first enabled source in priority order wins.
  function automatic logic [8:0] model_bus(input logic [11:0] cw, input logic pen,
                                           input logic [3:0] pc, input logic [7:0] ramv,
                                           input logic [7:0] ir, input logic [7:0] a,
                                           input logic [7:0] b);
    logic [11:0] act;
    logic        en  [5];
    logic [7:0]  val [5];
    logic [7:0]  alu;
    logic [7:0]  v;
    int          n;
    act = pen ? 12'h000 : (cw ^ MASK);
    alu = act[3] ? 8'(int'(a) - int'(b)) : 8'(int'(a) + int'(b));
    en  = '{act[10], act[8], act[6], act[4], act[2]};
    val = '{{4'h0, pc}, ramv, {4'h0, ir[3:0]}, a, alu};
    v = 8'h00;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (en[i]) begin
        if (n == 0) v = val[i];
        n++;
      end
    end
    return {(n > 1), v};
  endfunction

  assign m_act = control_word ^ MASK;
  assign {m_conf, m_busv} = model_bus(control_word, prog_en, m_pc, m_ram[m_mar], m_ir, m_a, m_b);

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pc  <= '0;
      m_mar <= '0;
      m_ir  <= '0;
      m_a   <= '0;
      m_b   <= '0;
      m_out <= '0;
    end else if (prog_en) begin
      if (prog_we) m_ram[prog_addr] <= prog_data;
    end else begin
      if (m_act[11]) m_pc  <= m_pc + 4'd1;
      if (m_act[9])  m_mar <= m_busv[3:0];
      if (m_act[7])  m_ir  <= m_busv;
      if (m_act[5])  m_a   <= m_busv;
      if (m_act[1])  m_b   <= m_busv;
      if (m_act[0])  m_out <= m_busv;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("bus",      bus_value, m_busv);
      check("conflict", {7'h0, bus_conflict}, {7'h0, m_conf});
      check("opcode",   {4'h0, opcode}, {4'h0, m_ir[7:4]});
      check("out",      out_value, m_out);
      check("halted",   {7'h0, halted}, {7'h0, (m_ir[7:4] == 4'hF)});
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [11:0] w(input logic [11:0] act);
    return act ^ MASK;
  endfunction

  task automatic drive(input logic [11:0] cw);
    @(posedge clock);
    #2;
    control_word = cw;
  endtask

  task automatic prog(input logic [3:0] a, input logic [7:0] d, input logic [11:0] cw);
    @(posedge clock);
    #2;
    prog_en = 1'b1;
    prog_we = 1'b1;
    prog_addr = a;
    prog_data = d;
    control_word = cw;
  endtask

  task automatic prog_off();
    @(posedge clock);
    #2;
    prog_en = 1'b0;
    prog_we = 1'b0;
    control_word = w(12'h000);
  endtask

  task automatic pulse_reset();
    drive(w(12'h000));
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_out", out_value, 8'h00);
    check("rst_opcode", {4'h0, opcode}, 8'h00);
    check("rst_bus", bus_value, 8'h00);
    @(posedge clock);
    #4 reset_n = 1'b1;
  endtask

  task automatic goto_pc(input logic [3:0] addr);
    logic [3:0] n;
    drive(w(12'h000));
    n = addr - m_pc;
    repeat (int'(n)) drive(w(F_CP));
  endtask

  task automatic load_from(input logic [3:0] addr, input logic [11:0] dest);
    goto_pc(addr);
    drive(w(F_EP | F_LM));
    drive(w(F_CE | dest));
  endtask

  task automatic fetch();
    drive(MASK ^ (F_EP | F_LM));
    drive(MASK ^ F_CP);
    drive(MASK ^ (F_CE | F_LI));
  endtask

  logic [7:0] init_ram [16];
  logic [7:0] prog_ram [16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    control_word = w(12'h000);
    prog_en = 1'b0;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_data = '0;
    init_ram = '{8'hA7, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    prog_ram = '{8'h09, 8'h1A, 8'h2B, 8'hE0, 8'hF0, 8'h00, 8'h00, 8'h00,
                 8'h00, 8'h10, 8'h14, 8'h18, 8'hF0, 8'h20, 8'h05, 8'h07};

    repeat (2) @(posedge clock);
    #1;
    check("init_opcode", {4'h0, opcode}, 8'h00);
    check("init_out", out_value, 8'h00);
    check("init_halted", {7'h0, halted}, 8'h00);
    check("init_bus", bus_value, 8'h00);
    check("init_conflict", {7'h0, bus_conflict}, 8'h00);
    @(posedge clock);
    #4 reset_n = 1'b1;

    for (int i = 0; i < 16; i++) prog(4'(i), init_ram[i], w(12'h000));
    prog_off();
    chk_en = 1'b1;

    // Garbage into A/B/OUT, then asynchronous reset clears them; RAM survives.
    drive(w(F_CE | F_LA | F_LB | F_LO));
    drive(w(F_EA));
    #1 check("garbage_a", bus_value, 8'hA7);
    check("garbage_out", out_value, 8'hA7);
    pulse_reset();
    drive(w(F_EA));
    #1 check("a_after_rst", bus_value, 8'h00);
    load_from(4'd3, 12'h000);
    #1 check("ram3_kept", bus_value, 8'h5A);

    // Fetch of RAM[0]=19.
    prog(4'd0, 8'h19, w(12'h000));
    prog_off();
    pulse_reset();
    fetch();
    drive(w(F_EP));
    #1 check("fetch_pc", bus_value, 8'h01);
    check("fetch_opcode", {4'h0, opcode}, 8'h01);
    drive(w(F_CE));
    #1 check("fetch_mar", bus_value, 8'h19);

    // Full program: LDA 9, ADD A, SUB B, OUT, HLT.
    for (int i = 0; i < 16; i++) prog(4'(i), prog_ram[i], w(12'h000));
    prog_off();
    pulse_reset();
    fetch();
    drive(w(F_EI | F_LM)); drive(w(F_CE | F_LA)); drive(w(12'h000));
    fetch();
    drive(w(F_EI | F_LM)); drive(w(F_CE | F_LB)); drive(w(F_EU | F_LA));
    fetch();
    drive(w(F_EI | F_LM)); drive(w(F_CE | F_LB)); drive(w(F_EU | F_SU | F_LA));
    fetch();
    drive(w(F_EA | F_LO)); drive(w(12'h000)); drive(w(12'h000));
    #1 check("prog_out", out_value, 8'h0C);
    check("prog_not_halted", {7'h0, halted}, 8'h00);
    fetch();
    drive(w(12'h000));
    #1 check("prog_halted", {7'h0, halted}, 8'h01);
    check("prog_hlt_op", {4'h0, opcode}, 8'h0F);

    // ALU wrap in both directions.
    load_from(4'd12, F_LA);
    load_from(4'd13, F_LB);
    drive(w(F_EU | F_LA));
    drive(w(F_EA));
    #1 check("add_wrap", bus_value, 8'h10);
    load_from(4'd14, F_LA);
    load_from(4'd15, F_LB);
    drive(w(F_EU | F_SU | F_LA));
    drive(w(F_EA));
    #1 check("sub_wrap", bus_value, 8'hFE);

    // PC wrap and bus conflict.
    pulse_reset();
    repeat (16) drive(w(F_CP));
    drive(w(F_EP));
    #1 check("pc_wrap", bus_value, 8'h00);
    repeat (5) drive(w(F_CP));
    drive(w(F_EP | F_EA));
    #1 check("conf_bus", bus_value, 8'h05);
    check("conf_flag", {7'h0, bus_conflict}, 8'h01);

    // Programming mode holds state despite Cp and nLa on the control word.
    load_from(4'd15, F_LA);
    for (int i = 0; i < 4; i++) prog(4'(i), 8'h31 + 8'(i), w(F_CP | F_LA));
    prog_off();
    drive(w(F_EP));
    #1 check("prog_pc_hold", bus_value, 8'h0F);
    drive(w(F_EA));
    #1 check("prog_a_hold", bus_value, 8'h07);
    load_from(4'd2, 12'h000);
    #1 check("prog_ram2", bus_value, 8'h33);
    @(posedge clock);
    #2;
    prog_we = 1'b1;
    prog_addr = 4'd2;
    prog_data = 8'hEE;
    control_word = w(12'h000);
    @(posedge clock);
    #2;
    prog_we = 1'b0;
    control_word = w(F_CE);
    #1 check("we_ignored", bus_value, 8'h33);
    drive(w(12'h000));
    drive(w(12'h000));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
